// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch-to-decode FIFO pairing each accepted pc with the instruction returned next cycle.
// Define IFQ_BYPASS_EN to forward a returning instruction straight to decode when the queue is empty.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      inst_sram_rdata,
    output logic             if_stall,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic [PTR_W:0]   ifq_count
);
    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_inst [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             req_valid_q;
    logic [31:0]      req_pc_q;
    logic             head_valid, accept, push, pop, byp, wr_en;
    always_comb begin
        head_valid = count != '0;
        // counting the in-flight request keeps a push from ever landing on a full queue
        if_stall   = ~flush & (({1'b0, count} + (PTR_W+2)'(req_valid_q)) >= (PTR_W+2)'(DEPTH));
        accept     = if_valid & ~if_stall & ~flush;
        push       = req_valid_q & ~flush;
`ifdef IFQ_BYPASS_EN
        byp        = ~head_valid & push & id_ready;
`else
        byp        = 1'b0;
`endif
        wr_en      = push & ~byp;
        pop        = head_valid & id_ready;
        id_valid   = head_valid | byp;
        id_pc      = head_valid ? mem_pc[rd_ptr]   : byp ? req_pc_q        : '0;
        id_inst    = head_valid ? mem_inst[rd_ptr] : byp ? inst_sram_rdata : '0;
    end
    assign ifq_count = count;
    always_ff @(posedge clk) begin
        if (wr_en & ~rst) begin
            mem_pc[wr_ptr]   <= req_pc_q;
            mem_inst[wr_ptr] <= inst_sram_rdata;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_valid_q <= 1'b0;
        end else begin
            req_valid_q <= accept;
            if (accept) req_pc_q <= if_pc;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized and directed scenarios checked against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic [31:0] if_pc, inst_sram_rdata;
    logic        if_stall, id_valid;
    logic [31:0] id_pc, id_inst;
    logic [2:0]  ifq_count;
    int checks = 0;
    int passed = 0;
    ent_t        q[$];
    logic        infl = 1'b0;
    logic [31:0] infl_pc = '0;
    logic        exp_byp, exp_valid, exp_stall;
    logic [31:0] exp_pc, exp_inst;
    logic [2:0]  exp_count;

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
        .inst_sram_rdata(inst_sram_rdata), .if_stall(if_stall), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .ifq_count(ifq_count)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs and derive what decode/fetch should see from the model
    task automatic apply(input logic r, f, v, input logic [31:0] pc, rd, input logic rdy);
        rst = r; flush = f; if_valid = v; if_pc = pc; inst_sram_rdata = rd; id_ready = rdy;
        exp_byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        exp_byp = q.size() == 0 && infl && rdy && !f;
`endif
        exp_valid = q.size() != 0 || exp_byp;
        exp_pc    = q.size() != 0 ? q[0].pc   : exp_byp ? infl_pc : 32'h0;
        exp_inst  = q.size() != 0 ? q[0].inst : exp_byp ? rd      : 32'h0;
        exp_stall = !f && (q.size() + int'(infl) >= DEPTH);
        exp_count = 3'(q.size());
        #2;
    endtask

    task automatic tick();
        ent_t e;
        if (rst || flush) begin
            q.delete();
            infl = 1'b0;
        end else begin
            if (q.size() != 0 && id_ready) void'(q.pop_front());
            if (infl && !exp_byp) begin
                e.pc = infl_pc; e.inst = inst_sram_rdata;
                q.push_back(e);
            end
            infl = if_valid && !exp_stall;
            infl_pc = if_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0); tick();
        apply(1, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        do_reset();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (id_valid !== 1'b0) $display("FAIL reset id_valid got=%0b exp=0", id_valid); else passed++;
        checks++; if (id_pc !== 32'h0) $display("FAIL reset id_pc got=%h exp=0", id_pc); else passed++;
        checks++; if (id_inst !== 32'h0) $display("FAIL reset id_inst got=%h exp=0", id_inst); else passed++;
        checks++; if (if_stall !== 1'b0) $display("FAIL reset if_stall got=%0b exp=0", if_stall); else passed++;
        checks++; if (ifq_count !== 3'd0) $display("FAIL reset ifq_count got=%0d exp=0", ifq_count); else passed++;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] pcs[3], insts[3], got_pc[$], got_inst[$];
        int got_cyc[$];
        logic [31:0] rd;
        pcs   = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008};
        insts = '{32'h24080001, 32'h24090002, 32'h240a0003};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            rd = (k >= 1 && k <= 3) ? insts[k-1] : $urandom;
            apply(0, 0, k < 3, k < 3 ? pcs[k] : 32'h0, rd, 1);
            checks++; if (id_valid !== exp_valid) $display("FAIL stream id_valid cyc%0d got=%0b exp=%0b", k, id_valid, exp_valid); else passed++;
            checks++; if (id_pc !== exp_pc) $display("FAIL stream id_pc cyc%0d got=%h exp=%h", k, id_pc, exp_pc); else passed++;
            checks++; if (id_inst !== exp_inst) $display("FAIL stream id_inst cyc%0d got=%h exp=%h", k, id_inst, exp_inst); else passed++;
            if (id_valid === 1'b1) begin
                got_pc.push_back(id_pc); got_inst.push_back(id_inst); got_cyc.push_back(k);
            end
            tick();
        end
        checks++; if (got_pc.size() != 3) $display("FAIL stream out_count got=%0d exp=3", got_pc.size()); else passed++;
        for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== pcs[i]) $display("FAIL stream seq_pc%0d got=%h exp=%h", i, got_pc[i], pcs[i]); else passed++;
            checks++; if (got_inst[i] !== insts[i]) $display("FAIL stream seq_inst%0d got=%h exp=%h", i, got_inst[i], insts[i]); else passed++;
            checks++; if (got_cyc[i] != LAT + i) $display("FAIL stream seq_cycle%0d got=%0d exp=%0d", i, got_cyc[i], LAT + i); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] base, pc, drained[$];
        base = 32'h80000000;
        pc = base;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            apply(0, 0, 1, pc, $urandom, 0);
            checks++; if (if_stall !== exp_stall) $display("FAIL bp if_stall cyc%0d got=%0b exp=%0b", k, if_stall, exp_stall); else passed++;
            checks++; if (ifq_count !== exp_count) $display("FAIL bp ifq_count cyc%0d got=%0d exp=%0d", k, ifq_count, exp_count); else passed++;
            if (if_stall === 1'b0) pc += 4;
            tick();
        end
        apply(0, 0, 1, pc, $urandom, 1);
        checks++; if (ifq_count !== 3'd4) $display("FAIL bp full_count got=%0d exp=4", ifq_count); else passed++;
        checks++; if (if_stall !== 1'b1) $display("FAIL bp full_stall got=%0b exp=1", if_stall); else passed++;
        checks++; if (id_pc !== base) $display("FAIL bp full_head got=%h exp=%h", id_pc, base); else passed++;
        tick();
        apply(0, 0, 1, pc, $urandom, 0);
        checks++; if (if_stall !== 1'b0) $display("FAIL bp release_stall got=%0b exp=0", if_stall); else passed++;
        checks++; if (id_pc !== base + 4) $display("FAIL bp release_head got=%h exp=%h", id_pc, base + 4); else passed++;
        checks++; if (ifq_count !== 3'd3) $display("FAIL bp release_count got=%0d exp=3", ifq_count); else passed++;
        tick();
        for (int k = 0; k < 6; k++) begin
            apply(0, 0, 0, 0, $urandom, 1);
            checks++; if (id_pc !== exp_pc) $display("FAIL bp drain_pc cyc%0d got=%h exp=%h", k, id_pc, exp_pc); else passed++;
            if (id_valid === 1'b1) drained.push_back(id_pc);
            tick();
        end
        checks++; if (drained.size() != 4) $display("FAIL bp drain_count got=%0d exp=4", drained.size()); else passed++;
        for (int i = 0; i < 4 && i < drained.size(); i++) begin
            checks++; if (drained[i] !== base + 32'(4 * (i + 1))) $display("FAIL bp drain_seq%0d got=%h exp=%h", i, drained[i], base + 32'(4 * (i + 1))); else passed++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] pc;
        logic seen;
        pc = 32'h9fc00000;
        seen = 1'b0;
        do_reset();
        for (int k = 0; k < 10 && !(q.size() == 3 && infl); k++) begin
            apply(0, 0, 1, pc, $urandom, 0);
            if (if_stall === 1'b0) pc += 4;
            tick();
        end
        apply(0, 1, 1, pc, 32'hdeadbeef, 1);
        checks++; if (if_stall !== 1'b0) $display("FAIL flush stall_in_flush got=%0b exp=0", if_stall); else passed++;
        tick();
        apply(0, 0, 1, 32'hbfc00100, 32'hdeadbeef, 1);
        checks++; if (ifq_count !== 3'd0) $display("FAIL flush count_after got=%0d exp=0", ifq_count); else passed++;
        checks++; if (id_valid !== 1'b0) $display("FAIL flush valid_after got=%0b exp=0", id_valid); else passed++;
        tick();
        for (int k = 0; k < 4 && !seen; k++) begin
            apply(0, 0, 0, 0, 32'h3c1d0001, 1);
            if (id_valid === 1'b1) begin
                seen = 1'b1;
                checks++; if (id_pc !== 32'hbfc00100) $display("FAIL flush first_pc got=%h exp=bfc00100", id_pc); else passed++;
                checks++; if (id_inst !== 32'h3c1d0001) $display("FAIL flush first_inst got=%h exp=3c1d0001", id_inst); else passed++;
            end
            tick();
        end
        checks++; if (!seen) $display("FAIL flush first_out got=none exp=bfc00100"); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        logic rdy;
        int idx;
        idx = 0;
        do_reset();
        for (int k = 0; k < 200 && got.size() < 10; k++) begin
            rdy = 1'($urandom);
            apply(0, 0, idx < 10, 32'h100 + 32'(4 * idx), $urandom, rdy);
            checks++; if (id_pc !== exp_pc) $display("FAIL wrap id_pc cyc%0d got=%h exp=%h", k, id_pc, exp_pc); else passed++;
            checks++; if (ifq_count > 3'd4) $display("FAIL wrap overflow got=%0d exp<=4", ifq_count); else passed++;
            if (id_valid === 1'b1 && rdy) got.push_back(id_pc);
            if (if_stall === 1'b0 && idx < 10) idx++;
            tick();
        end
        checks++; if (got.size() != 10) $display("FAIL wrap out_count got=%0d exp=10", got.size()); else passed++;
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checks++; if (got[i] !== 32'h100 + 32'(4 * i)) $display("FAIL wrap seq%0d got=%h exp=%h", i, got[i], 32'h100 + 32'(4 * i)); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pc;
        pc = 32'h400000;
        for (int k = 0; k < 12 && !(if_stall === 1'b1 && ifq_count === 3'd4); k++) begin
            apply(0, 0, 1, pc, $urandom, 0);
            if (if_stall === 1'b0) pc += 4;
            if (!(if_stall === 1'b1 && ifq_count === 3'd4)) tick();
        end
        checks++; if (ifq_count !== 3'd4 || if_stall !== 1'b1) $display("FAIL rstmid precondition got=%0d/%0b exp=4/1", ifq_count, if_stall); else passed++;
        apply(1, 1, 1, pc, $urandom, 1);
        tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (id_valid !== 1'b0) $display("FAIL rstmid id_valid got=%0b exp=0", id_valid); else passed++;
        checks++; if (id_pc !== 32'h0) $display("FAIL rstmid id_pc got=%h exp=0", id_pc); else passed++;
        checks++; if (id_inst !== 32'h0) $display("FAIL rstmid id_inst got=%h exp=0", id_inst); else passed++;
        checks++; if (if_stall !== 1'b0) $display("FAIL rstmid if_stall got=%0b exp=0", if_stall); else passed++;
        checks++; if (ifq_count !== 3'd0) $display("FAIL rstmid ifq_count got=%0d exp=0", ifq_count); else passed++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            apply(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0), 1'($urandom),
                  $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
            checks++; if (id_valid !== exp_valid) $display("FAIL rand id_valid cyc%0d got=%0b exp=%0b", k, id_valid, exp_valid); else passed++;
            checks++; if (id_pc !== exp_pc) $display("FAIL rand id_pc cyc%0d got=%h exp=%h", k, id_pc, exp_pc); else passed++;
            checks++; if (id_inst !== exp_inst) $display("FAIL rand id_inst cyc%0d got=%h exp=%h", k, id_inst, exp_inst); else passed++;
            checks++; if (if_stall !== exp_stall) $display("FAIL rand if_stall cyc%0d got=%0b exp=%0b", k, if_stall, exp_stall); else passed++;
            checks++; if (ifq_count !== exp_count) $display("FAIL rand ifq_count cyc%0d got=%0d exp=%0d", k, ifq_count, exp_count); else passed++;
            tick();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
